// File: rtl/lieat_general_radix_4_otfc.sv
// lieat_general_radix_4_otfc: radix-4 on-the-fly quotient converter; optional one-hot checker via LIEAT_OTFC_ONEHOT_CHK_EN
module lieat_general_radix_4_otfc #(
  parameter int WIDTH = 32,
  parameter int QUOT_ONEHOT_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         digit_valid_i,
  output logic                         digit_ready_o,
  input  logic [QUOT_ONEHOT_WIDTH-1:0] digit_i,
  input  logic                         sign_valid_i,
  output logic                         sign_ready_o,
  input  logic                         rem_neg_i,
  output logic                         quot_valid_o,
  input  logic                         quot_ready_i,
  output logic [WIDTH-1:0]             quot_o,
  output logic                         err_o
);
  localparam int NDIG = WIDTH / 2;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
  typedef enum logic [1:0] {IDLE, ACCUM, SIGN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] q, qm, q_n, qm_n;
  logic [WIDTH-3:0] qt, qmt;
  logic [CW-1:0] cnt;
  logic dig_acc, sign_acc;
  assign digit_ready_o = state == ACCUM;
  assign sign_ready_o = state == SIGN;
  assign quot_valid_o = state == DONE;
  assign dig_acc = digit_valid_i && digit_ready_o;
  assign sign_acc = sign_valid_i && sign_ready_o;
  assign qt = q[WIDTH-3:0];
  assign qmt = qm[WIDTH-3:0];
  // lowest set bit wins; an all-zero digit falls through to the zero-digit update
  always_comb begin
    {q_n, qm_n} = digit_i[0] ? {qmt, 2'b10, qmt, 2'b01} :
                  digit_i[1] ? {qmt, 2'b11, qmt, 2'b10} :
                  digit_i[2] ? {qt, 2'b00, qmt, 2'b11} :
                  digit_i[3] ? {qt, 2'b01, qt, 2'b00} :
                  digit_i[4] ? {qt, 2'b10, qt, 2'b01} :
                               {qt, 2'b00, qmt, 2'b11};
  end
  always_comb begin
    state_n = state;
    if (start_i) state_n = ACCUM;
    else if (dig_acc && cnt == LAST) state_n = SIGN;
    else if (sign_acc) state_n = DONE;
    else if (quot_valid_o && quot_ready_i) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q <= '0;
      qm <= '0;
      cnt <= '0;
      quot_o <= '0;
    end else begin
      state <= state_n;
      if (start_i) begin
        q <= '0;
        qm <= '1;
        cnt <= '0;
      end else if (dig_acc) begin
        q <= q_n;
        qm <= qm_n;
        cnt <= cnt + CW'(1);
      end
      if (!start_i && sign_acc) quot_o <= rem_neg_i ? qm : q;
    end
  end
`ifdef LIEAT_OTFC_ONEHOT_CHK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst || start_i) err_q <= 1'b0;
    else if (dig_acc && !$onehot(digit_i)) err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_lieat_general_radix_4_otfc.sv
// tb_lieat_general_radix_4_otfc: directed and randomized checks of the OTFC against a digit-weighted-sum model
module tb_lieat_general_radix_4_otfc;
  localparam int W = 8;
  localparam int N = W / 2;
  localparam logic [4:0] M2 = 5'b00001, M1 = 5'b00010, Z = 5'b00100, P1 = 5'b01000, P2 = 5'b10000;
`ifdef LIEAT_OTFC_ONEHOT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 0, rst = 1, start_i = 0, digit_valid_i = 0, sign_valid_i = 0, rem_neg_i = 0, quot_ready_i = 0;
  logic [4:0] digit_i = '0;
  logic digit_ready_o, sign_ready_o, quot_valid_o, err_o;
  logic [W-1:0] quot_o;
  int ncmp = 0, nfail = 0;
  logic [4:0] dq [N];
  bit err_m = 0;

  lieat_general_radix_4_otfc #(.WIDTH(W), .QUOT_ONEHOT_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .digit_valid_i(digit_valid_i),
    .digit_ready_o(digit_ready_o), .digit_i(digit_i), .sign_valid_i(sign_valid_i),
    .sign_ready_o(sign_ready_o), .rem_neg_i(rem_neg_i), .quot_valid_o(quot_valid_o),
    .quot_ready_i(quot_ready_i), .quot_o(quot_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // digit value is its one-hot bit index minus two; lowest set bit wins
  function automatic int dec(input logic [4:0] x);
    for (int b = 0; b < 5; b++) if (x[b]) return b - 2;
    return 0;
  endfunction

  // quotient = sum of digits weighted by powers of four, minus one when the remainder is negative
  function automatic logic [W-1:0] model(input bit neg);
    int v;
    v = 0;
    for (int i = 0; i < N; i++) v = v * 4 + dec(dq[i]);
    v = v - int'(neg);
    return W'(v);
  endfunction

  task automatic setd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
    dq[0] = a; dq[1] = b; dq[2] = c; dq[3] = d;
  endtask

  task automatic start_pulse();
    @(negedge clk) start_i = 1;
    @(negedge clk) start_i = 0;
    err_m = 0;
    chk("acc_ready", digit_ready_o, 1);
    chk("err_clr", err_o, 0);
  endtask

  task automatic feed(input int cnt, input bit rnd);
    for (int i = 0; i < cnt; i++) begin
      int gaps;
      gaps = 0;
      while (rnd && gaps < 6 && $urandom_range(1, 0) == 1) begin
        digit_valid_i = 0;
        digit_i = 5'($urandom);
        @(negedge clk);
        chk("ready_hold", digit_ready_o, 1);
        gaps++;
      end
      digit_valid_i = 1;
      digit_i = dq[i];
      @(negedge clk);
      digit_valid_i = 0;
      if ($countones(dq[i]) != 1) err_m = CHK;
      chk("err", err_o, err_m);
    end
    if (cnt == N) begin
      chk("ready_off", digit_ready_o, 0);
      chk("sign_ready", sign_ready_o, 1);
    end
  endtask

  task automatic sign_phase(input bit neg, input bit rnd);
    int w;
    w = rnd ? int'($urandom_range(3, 0)) : 0;
    repeat (w) begin
      @(negedge clk);
      chk("sign_wait", sign_ready_o, 1);
    end
    sign_valid_i = 1;
    rem_neg_i = neg;
    @(negedge clk);
    sign_valid_i = 0;
    rem_neg_i = 1'($urandom);
    chk("qvalid", quot_valid_o, 1);
    chk("quot", quot_o, model(neg));
    chk("sign_off", sign_ready_o, 0);
  endtask

  task automatic done_phase(input int hold, input bit neg, input bit b2b);
    repeat (hold) begin
      quot_ready_i = 0;
      digit_valid_i = 1'($urandom);
      @(negedge clk);
      chk("hold_q", quot_o, model(neg));
      chk("hold_v", quot_valid_o, 1);
      chk("hold_dr", digit_ready_o, 0);
    end
    digit_valid_i = 0;
    quot_ready_i = 1;
    start_i = b2b;
    @(negedge clk);
    quot_ready_i = 0;
    start_i = 0;
    if (b2b) err_m = 0;
    chk("after_v", quot_valid_o, 0);
    chk("after_q", quot_o, model(neg));
    chk("after_dr", digit_ready_o, b2b);
  endtask

  task automatic run(input bit neg, input bit rnd, input int hold);
    start_pulse();
    feed(N, rnd);
    sign_phase(neg, rnd);
    done_phase(hold, neg, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_dr", digit_ready_o, 0);
    chk("rst_sr", sign_ready_o, 0);
    chk("rst_qv", quot_valid_o, 0);
    chk("rst_q", quot_o, 0);
    chk("rst_err", err_o, 0);
    rst = 0;
    digit_valid_i = 1; digit_i = P2;
    @(negedge clk);
    digit_valid_i = 0;
    chk("idle_dr", digit_ready_o, 0);
    setd(P1, P2, Z, M1);
    run(0, 0, 0); chk("vec_5f", quot_o, 8'h5F);
    run(1, 0, 0); chk("vec_5e", quot_o, 8'h5E);
    setd(P2, P2, P2, P2);
    run(0, 0, 0); chk("vec_aa", quot_o, 8'hAA);
    run(1, 0, 0); chk("vec_a9", quot_o, 8'hA9);
    setd(M2, Z, Z, Z);
    run(0, 0, 0); chk("vec_80", quot_o, 8'h80);
    setd(P1, P2, Z, M1);
    run(0, 1, 5); chk("stall_5f", quot_o, 8'h5F);
    setd(P2, M2, P2, M2);
    start_pulse();
    feed(2, 0);
    setd(P1, P2, Z, M1);
    run(0, 0, 0); chk("abort_5f", quot_o, 8'h5F);
    setd(P2, P2, P2, P2);
    start_pulse();
    feed(N, 0);
    sign_phase(0, 0);
    done_phase(0, 0, 1);
    setd(P1, P2, Z, M1);
    feed(N, 0);
    sign_phase(1, 0);
    done_phase(1, 1, 0); chk("b2b_5e", quot_o, 8'h5E);
    setd(M1, M1, M1, M1);
    start_pulse();
    feed(2, 0);
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    chk("mrst_dr", digit_ready_o, 0);
    chk("mrst_sr", sign_ready_o, 0);
    chk("mrst_qv", quot_valid_o, 0);
    chk("mrst_q", quot_o, 0);
    chk("mrst_err", err_o, 0);
    setd(5'b01010, Z, Z, Z);
    run(0, 0, 0); chk("illegal_c0", quot_o, 8'hC0);
    chk("err_sticky", err_o, CHK);
    setd(Z, Z, 5'b00000, P1);
    run(0, 0, 0); chk("zero_01", quot_o, 8'h01);
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++)
        dq[i] = ($urandom_range(3, 0) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(4, 0));
      run(1'($urandom), 1, int'($urandom_range(2, 0)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
